// File: rtl/palette_lut.sv
// Final pixel stage: 9-bit palette index -> RGB332, with sync/blank delayed to match.
// CPU palette writes are queued in a small FIFO and drained only during blanking.
module palette_lut #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [8:0]        indexIn,
  input  logic              blank_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_valid,
  input  logic [8:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out,
  output logic              init_done
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [8:0]        addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t     state, state_nxt;
  logic [8:0] init_cnt, init_cnt_nxt;
  logic       init_done_nxt;

  // ---------------- init / run sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      init_done <= init_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    init_cnt_nxt  = init_cnt;
    init_done_nxt = init_done;
    case (state)
      INIT: begin
        init_cnt_nxt = init_cnt + 9'd1;
        if (init_cnt == 9'd511) begin
          state_nxt     = RUN;
          init_done_nxt = 1'b1;
        end
      end
      RUN: init_cnt_nxt = init_cnt;
    endcase
  end

  // ---------------- CPU write FIFO ----------------
  wr_req_t       fifo_mem [FIFO_DEPTH];
  wr_req_t       head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign wr_ready = init_done && !full;
  assign push     = wr_valid && wr_ready;
  // Gated by reset so a queued entry cannot land in the palette on the reset edge.
  assign pop      = (state == RUN) && !empty && blank_in && !reset;
  assign head     = fifo_mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{addr: wr_addr, data: wr_data};
  end

  // ---------------- palette RAM (read-first) ----------------
  logic [DATA_W-1:0] ram [512];
  logic [DATA_W-1:0] ram_q;
  logic              ram_we;
  logic [8:0]        ram_wa;
  logic [DATA_W-1:0] ram_wd;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = head.addr;
    ram_wd = head.data;
    if (!reset) begin
      if (state == INIT) begin
        ram_we = 1'b1;
        ram_wa = init_cnt;
        ram_wd = '0;
      end else if (pop) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    if (enable) ram_q <= ram[indexIn];
  end

  // ---------------- pixel pipeline ----------------
  // init_d1 travels with the pixel so any read taken during INIT is masked at stage 2.
  logic blank_d1, hsync_d1, vsync_d1, init_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_d1  <= 1'b1;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
      init_d1   <= 1'b1;
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else if (enable) begin
      blank_d1  <= blank_in;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
      init_d1   <= (state == INIT);
      rgb       <= (blank_d1 || init_d1) ? '0 : ram_q;
      hsync_out <= hsync_d1;
      vsync_out <= vsync_d1;
      blank_out <= blank_d1;
    end
  end

endmodule

// File: tb/tb_palette_lut.sv
// Bench for palette_lut: directed scenarios plus random traffic, all outputs
// compared every clock against a queue-based behavioural model.
module tb_palette_lut;
  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b1, blank_in = 1'b1;
  logic       hsync_in = 1'b1, vsync_in = 1'b1, wr_valid = 1'b0;
  logic [8:0] indexIn = '0, wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, hsync_out, vsync_out, blank_out, init_done;
  logic [7:0] rgb;

  int total = 0, bad = 0;

  palette_lut #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .indexIn(indexIn),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rgb(rgb), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .blank_out(blank_out), .init_done(init_done)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [8:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] c; logic hs; logic vs; logic bl; } px_t;

  logic [7:0] pal [512];
  wr_t        fq [$];   // pending CPU writes, oldest first
  px_t        pq [$];   // pixels sampled on the last enable edges
  px_t        m_out;
  int         e = 0;    // clk edges since reset release (saturates at 512)

  task automatic model_edge();
    px_t p;
    wr_t w;
    bit  run, rdy, do_pop;
    if (reset) begin
      e = 0;
      fq.delete();
      pq.delete();
      foreach (pal[i]) pal[i] = 8'h00;
      m_out = '{8'h00, 1'b1, 1'b1, 1'b1};
      return;
    end
    run    = (e >= 512);
    rdy    = run && (fq.size() < 4);
    do_pop = run && (fq.size() > 0) && blank_in;
    if (enable) begin
      p.c  = (blank_in || !run) ? 8'h00 : pal[indexIn];
      p.hs = hsync_in;
      p.vs = vsync_in;
      p.bl = blank_in;
      pq.push_back(p);
      if (pq.size() > 2) void'(pq.pop_front());
      if (pq.size() == 2) m_out = pq[0];
    end
    if (do_pop) begin
      w = fq.pop_front();
      pal[w.a] = w.d;
    end
    if (wr_valid && rdy) begin
      w.a = wr_addr;
      w.d = wr_data;
      fq.push_back(w);
    end
    if (e < 512) e++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rgb",       rgb,       m_out.c);
    chk("hsync_out", hsync_out, m_out.hs);
    chk("vsync_out", vsync_out, m_out.vs);
    chk("blank_out", blank_out, m_out.bl);
    chk("init_done", init_done, e >= 512);
    chk("wr_ready",  wr_ready,  (e >= 512) && (fq.size() < 4));
  endtask

  task automatic push(input logic [8:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic show(input logic [8:0] idx);
    indexIn = idx; blank_in = 1'b0; enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_init();
    for (int i = 1; i <= 512; i++) begin
      tick();
      if (i == 511) begin
        chk("init_done_511", init_done, 0);
        chk("wr_ready_511",  wr_ready,  0);
      end
      if (i == 512) begin
        chk("init_done_512", init_done, 1);
        chk("wr_ready_512",  wr_ready,  1);
      end
    end
  endtask

  initial begin
    m_out = '{8'h00, 1'b1, 1'b1, 1'b1};
    foreach (pal[i]) pal[i] = 8'h00;

    // reset and init
    repeat (3) tick();
    chk("rst_rgb", rgb, 0);
    chk("rst_hsync", hsync_out, 1);
    chk("rst_vsync", vsync_out, 1);
    chk("rst_blank", blank_out, 1);
    chk("rst_ready", wr_ready, 0);
    chk("rst_done", init_done, 0);
    reset = 1'b0;
    run_init();

    // sweep: whole palette reads zero
    blank_in = 1'b0;
    for (int i = 0; i < 512; i++) begin
      indexIn = 9'(i);
      tick();
    end
    tick();
    tick();

    // write during blank
    blank_in = 1'b1;
    push(9'h007, 8'h6C);
    tick();
    show(9'h007);
    chk("wr_blank", rgb, 8'h6C);

    // deferred writes and FIFO full
    blank_in = 1'b0;
    for (int i = 0; i < 4; i++) push(9'(9'h010 + i), 8'(8'hA1 + i));
    chk("full_ready", wr_ready, 0);
    show(9'h010);
    chk("deferred_old", rgb, 8'h00);
    blank_in = 1'b1;
    repeat (4) tick();
    chk("drain_ready", wr_ready, 1);
    show(9'h012);
    chk("drain_data", rgb, 8'hA3);

    // gated enable latency
    indexIn = 9'h007; blank_in = 1'b0; hsync_in = 1'b0; enable = 1'b1;
    tick();
    hsync_in = 1'b1; enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("gate_hsync", hsync_out, 0);
    chk("gate_rgb", rgb, 8'h6C);
    enable = 1'b0;
    tick();
    chk("hold_hsync", hsync_out, 0);
    chk("hold_rgb", rgb, 8'h6C);
    enable = 1'b1;
    tick();
    chk("gate_hsync_back", hsync_out, 1);

    // blank forcing and same-address ordering
    indexIn = 9'h007; blank_in = 1'b1;
    tick();
    tick();
    chk("blank_force", rgb, 0);
    tick();
    chk("blank_force2", rgb, 0);
    blank_in = 1'b0;
    push(9'h020, 8'h11);
    push(9'h020, 8'h22);
    blank_in = 1'b1;
    tick();
    tick();
    show(9'h020);
    chk("same_addr", rgb, 8'h22);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      enable   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) blank_in = ~blank_in;
      hsync_in = ($urandom_range(0, 7) != 0);
      vsync_in = ($urandom_range(0, 7) != 0);
      indexIn  = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                             : 9'($urandom_range(0, 31));
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr  = 9'($urandom_range(0, 31));
      wr_data  = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0; enable = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;

    // reset in the middle of init
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (200) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_init();

    // reset with writes queued
    blank_in = 1'b0;
    push(9'h030, 8'h5A);
    push(9'h031, 8'hA5);
    blank_in = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_init();
    show(9'h030);
    chk("lost_030", rgb, 0);
    show(9'h031);
    chk("lost_031", rgb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
